lock_code_player: RTL and testbench

Sequence generator for the button-combination lock interface. On a `start` request it replays a stored 4-step unlock code as timed one-hot button presses on a 4-bit button bus. Each press is separated by a release gap, so the lock's per-button edge detectors register every step as a distinct press. It sits on the driving side of the lock and is used for automated unlock, self-test and bench stimulus.

---
 rtl/lock_code_player_pkg.sv | 33 +++
 rtl/lock_code_player_if.sv | 36 +++
 rtl/lock_code_player_press_timer.sv | 27 ++
 rtl/lock_code_player.sv | 102 ++++++++++
 tb/tb_lock_code_player.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lock_code_player_pkg.sv
// Shared definitions for the button-combination lock sequence player:
// button indices, FSM state type, default unlock code and one-hot decode.
package lock_pkg;

   localparam logic [1:0] BTN_A = 2'd0;
   localparam logic [1:0] BTN_B = 2'd1;
   localparam logic [1:0] BTN_C = 2'd2;
   localparam logic [1:0] BTN_D = 2'd3;

   // Step0 in [1:0]: D, B, C, A
   localparam logic [7:0] LOCK_DEFAULT_CODE = 8'h27;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRESS,
      ST_GAP,
      ST_FINISH
   } state_t;

   function automatic logic [3:0] btn_onehot(input logic [1:0] idx);
      logic [3:0] w_oh;
      w_oh = '0;
      unique case (idx)
         BTN_A: w_oh = 4'b0001;
         BTN_B: w_oh = 4'b0010;
         BTN_C: w_oh = 4'b0100;
         BTN_D: w_oh = 4'b1000;
         default: w_oh = '0;
      endcase
      return w_oh;
   endfunction

endpackage

// File: rtl/lock_code_player_if.sv
// Button-bus handshake between a sequence driver and the code player.
// Optional abort line present only when LOCK_PLAYER_ABORT_EN is defined.
interface lock_code_player_if;

   logic       start;
   logic [7:0] code;
   logic [3:0] btn;
   logic       busy;
   logic       done;
`ifdef LOCK_PLAYER_ABORT_EN
   logic       abort;
`endif

   modport master (
`ifdef LOCK_PLAYER_ABORT_EN
      output abort,
`endif
      output start,
      output code,
      input  btn,
      input  busy,
      input  done
   );

   modport slave (
`ifdef LOCK_PLAYER_ABORT_EN
      input  abort,
`endif
      input  start,
      input  code,
      output btn,
      output busy,
      output done
   );

endinterface

// File: rtl/lock_code_player_press_timer.sv
// Loadable down-counter shared by the PRESS and GAP phases; expired
// is high while the count sits at zero.
module press_timer #(
   parameter int unsigned W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         expired
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= value;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign expired = (r_cnt == '0);

endmodule

// File: rtl/lock_code_player.sv
// Replays a latched 4-step unlock code as timed one-hot button presses
// separated by release gaps. Optional abort input: LOCK_PLAYER_ABORT_EN.
module lock_code_player
   import lock_pkg::*;
#(
   parameter int unsigned PULSE_CYCLES = 2,
   parameter int unsigned GAP_CYCLES   = 3
) (
   input  logic              clk,
   input  logic              rst,
   lock_code_player_if.slave bus
);

   localparam int unsigned MAXC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
   localparam int unsigned CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] LD_PULSE = CW'(PULSE_CYCLES - 1);
   localparam logic [CW-1:0] LD_GAP   = CW'(GAP_CYCLES - 1);

   state_t        r_state;
   state_t        w_next;
   logic [1:0]    r_step;
   logic [7:0]    r_code;
   logic          w_expired;
   logic          w_load;
   logic [CW-1:0] w_load_val;
   logic [3:0]    w_btn;
   logic          w_busy;
   logic          w_done;
   logic          w_abort;

`ifdef LOCK_PLAYER_ABORT_EN
   assign w_abort = bus.abort;
`else
   assign w_abort = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_step  <= '0;
         r_code  <= LOCK_DEFAULT_CODE;
      end else begin
         r_state <= w_next;
         if (r_state == ST_IDLE && bus.start) begin
            r_code <= bus.code;
            r_step <= '0;
         end else if (r_state == ST_GAP && w_next == ST_PRESS) begin
            r_step <= r_step + 2'd1;
         end
      end
   end

   always_comb begin
      w_next = r_state;
      w_btn  = '0;
      w_busy = 1'b1;
      w_done = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            w_busy = 1'b0;
            if (bus.start) w_next = ST_PRESS;
         end
         ST_PRESS: begin
            w_btn = btn_onehot(r_code[{r_step, 1'b0} +: 2]);
            if (w_expired) w_next = (r_step == 2'd3) ? ST_FINISH : ST_GAP;
         end
         ST_GAP: begin
            if (w_expired) w_next = ST_PRESS;
         end
         ST_FINISH: begin
            w_done = 1'b1;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
      // Abort overrides any transition, but done in FINISH is already driven
      if (w_abort && r_state != ST_IDLE) w_next = ST_IDLE;
   end

   // Timer is reloaded on every state change so each phase starts fresh
   always_comb begin
      w_load     = (w_next != r_state);
      w_load_val = '0;
      if (w_next == ST_PRESS)    w_load_val = LD_PULSE;
      else if (w_next == ST_GAP) w_load_val = LD_GAP;
   end

   press_timer #(
      .W(CW)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (w_load),
      .value   (w_load_val),
      .expired (w_expired)
   );

   assign bus.btn  = w_btn;
   assign bus.busy = w_busy;
   assign bus.done = w_done;

endmodule

// File: tb/tb_lock_code_player.sv
// Directed self-checking bench for lock_code_player (default and 1/1 timing);
// abort scenario compiled in when LOCK_PLAYER_ABORT_EN is defined.
module tb_lock_code_player;
   import lock_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   lock_code_player_if bus ();
   lock_code_player_if bus_f ();

   lock_code_player #(.PULSE_CYCLES(2), .GAP_CYCLES(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   lock_code_player #(.PULSE_CYCLES(1), .GAP_CYCLES(1)) dut_f (
      .clk (clk),
      .rst (rst),
      .bus (bus_f)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Timeline model: cycle k=1 is the first cycle after the start edge
   function automatic logic [3:0] exp_btn(input logic [7:0] c, input int p, input int g, input int k);
      int s;
      int off;
      logic [1:0] idx;
      if (k < 1 || k > 4 * p + 3 * g) return 4'b0000;
      s   = (k - 1) / (p + g);
      off = (k - 1) % (p + g);
      if (off >= p) return 4'b0000;
      idx = c[2 * s +: 2];
      return 4'b0001 << idx;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b1;
      bus.code  = 8'h27;
      tick();
      tick();
      total += 4;
      if (bus.btn !== 4'b0000) begin bad++; $display("FAIL reset_btn got=%b want=0000", bus.btn); end
      if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
      if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
      if (bus_f.busy !== 1'b0) begin bad++; $display("FAIL reset_busy_f got=%b want=0", bus_f.busy); end
      bus.start = 1'b0;
      rst = 1'b0;
      tick();
      total++;
      if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b want=0", bus.busy); end
   endtask

   task automatic test_default();
      logic [3:0] exp_tab [18] = '{4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000,
                                   4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000,
                                   4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000,
                                   4'b0001, 4'b0001, 4'b0000};
      logic [3:0] want;
      logic [3:0] prev = 4'b0000;
      logic [7:0] seq  = 8'h00;
      int presses = 0;
      bus.code  = LOCK_DEFAULT_CODE;
      bus.start = 1'b1;
      for (int k = 1; k <= 21; k++) begin
         tick();
         if (k == 1) bus.start = 1'b0;
         want = (k <= 18) ? exp_tab[k - 1] : 4'b0000;
         total += 3;
         if (bus.btn !== want) begin bad++; $display("FAIL default_btn k=%0d got=%b want=%b", k, bus.btn, want); end
         if (bus.busy !== (k <= 18)) begin bad++; $display("FAIL default_busy k=%0d got=%b want=%b", k, bus.busy, k <= 18); end
         if (bus.done !== (k == 18)) begin bad++; $display("FAIL default_done k=%0d got=%b want=%b", k, bus.done, k == 18); end
         // Downstream lock: record the button index on every rising press
         if (prev == 4'b0000 && bus.btn != 4'b0000) begin
            presses++;
            for (int b = 0; b < 4; b++)
               if (bus.btn[b]) seq = {2'(b), seq[7:2]};
         end
         prev = bus.btn;
      end
      total += 2;
      if (presses !== 4) begin bad++; $display("FAIL default_presses got=%0d want=4", presses); end
      if (seq !== LOCK_DEFAULT_CODE) begin bad++; $display("FAIL default_unlock got=%h want=%h", seq, LOCK_DEFAULT_CODE); end
   endtask

   task automatic test_repeated();
      logic prev0 = 1'b0;
      int rises = 0;
      int run = 0;
      int maxrun = 0;
      int dones = 0;
      bus.code  = 8'h00;
      bus.start = 1'b1;
      for (int k = 1; k <= 21; k++) begin
         tick();
         if (k == 1) bus.start = 1'b0;
         total++;
         if ($countones(bus.btn) > 1 || bus.btn[3:1] != 3'b000) begin
            bad++; $display("FAIL repeat_onehot k=%0d got=%b want=000x", k, bus.btn);
         end
         if (bus.btn[0] && !prev0) rises++;
         run = bus.btn[0] ? run + 1 : 0;
         if (run > maxrun) maxrun = run;
         if (bus.done) dones++;
         prev0 = bus.btn[0];
      end
      total += 3;
      if (rises !== 4) begin bad++; $display("FAIL repeat_rises got=%0d want=4", rises); end
      if (maxrun !== 2) begin bad++; $display("FAIL repeat_maxrun got=%0d want=2", maxrun); end
      if (dones !== 1) begin bad++; $display("FAIL repeat_dones got=%0d want=1", dones); end
   endtask

   task automatic test_start_while_busy();
      int busy_cnt = 0;
      int dones = 0;
      bus.code  = 8'h27;
      bus.start = 1'b1;
      for (int k = 1; k <= 22; k++) begin
         tick();
         if (k == 1) bus.start = 1'b0;
         total++;
         if (bus.btn !== exp_btn(8'h27, 2, 3, k)) begin
            bad++; $display("FAIL busy_ignore_btn k=%0d got=%b want=%b", k, bus.btn, exp_btn(8'h27, 2, 3, k));
         end
         if (bus.busy) busy_cnt++;
         if (bus.done) dones++;
         if (k == 5) begin bus.start = 1'b1; bus.code = 8'hFF; end
         if (k == 6) bus.start = 1'b0;
      end
      total += 2;
      if (busy_cnt !== 18) begin bad++; $display("FAIL busy_ignore_cycles got=%0d want=18", busy_cnt); end
      if (dones !== 1) begin bad++; $display("FAIL busy_ignore_dones got=%0d want=1", dones); end
   endtask

   task automatic test_reset_mid();
      bus.code  = 8'h27;
      bus.start = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k == 1) bus.start = 1'b0;
      end
      total++;
      if (bus.btn !== 4'b0010) begin bad++; $display("FAIL rstmid_press2 got=%b want=0010", bus.btn); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total += 3;
      if (bus.btn !== 4'b0000) begin bad++; $display("FAIL rstmid_btn got=%b want=0000", bus.btn); end
      if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", bus.busy); end
      if (bus.done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b want=0", bus.done); end
      for (int k = 0; k < 4; k++) begin
         tick();
         total++;
         if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++; $display("FAIL rstmid_quiet k=%0d busy=%b done=%b want=0/0", k, bus.busy, bus.done);
         end
      end
      bus.code  = 8'hE4;
      bus.start = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (k == 1) bus.start = 1'b0;
         total += 2;
         if (bus.btn !== exp_btn(8'hE4, 2, 3, k)) begin
            bad++; $display("FAIL rstmid_replay_btn k=%0d got=%b want=%b", k, bus.btn, exp_btn(8'hE4, 2, 3, k));
         end
         if (bus.done !== (k == 18)) begin bad++; $display("FAIL rstmid_replay_done k=%0d got=%b", k, bus.done); end
      end
   endtask

   task automatic test_back_to_back();
      int j;
      bus.code  = 8'h27;
      bus.start = 1'b1;
      for (int k = 1; k <= 38; k++) begin
         tick();
         j = (k - 1) % 19 + 1;
         total += 3;
         if (bus.btn !== exp_btn(8'h27, 2, 3, j)) begin
            bad++; $display("FAIL b2b_btn k=%0d got=%b want=%b", k, bus.btn, exp_btn(8'h27, 2, 3, j));
         end
         if (bus.busy !== (j <= 18)) begin bad++; $display("FAIL b2b_busy k=%0d got=%b want=%b", k, bus.busy, j <= 18); end
         if (bus.done !== (j == 18)) begin bad++; $display("FAIL b2b_done k=%0d got=%b want=%b", k, bus.done, j == 18); end
         if (k == 37) bus.start = 1'b0;
      end
   endtask

   task automatic test_fast();
      int busy_cnt = 0;
      bus_f.code  = 8'h27;
      bus_f.start = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k == 1) bus_f.start = 1'b0;
         total += 3;
         if (bus_f.btn !== exp_btn(8'h27, 1, 1, k) || $countones(bus_f.btn) > 1) begin
            bad++; $display("FAIL fast_btn k=%0d got=%b want=%b", k, bus_f.btn, exp_btn(8'h27, 1, 1, k));
         end
         if (bus_f.busy !== (k <= 8)) begin bad++; $display("FAIL fast_busy k=%0d got=%b want=%b", k, bus_f.busy, k <= 8); end
         if (bus_f.done !== (k == 8)) begin bad++; $display("FAIL fast_done k=%0d got=%b want=%b", k, bus_f.done, k == 8); end
         if (bus_f.busy) busy_cnt++;
      end
      total++;
      if (busy_cnt !== 8) begin bad++; $display("FAIL fast_cycles got=%0d want=8", busy_cnt); end
   endtask

`ifdef LOCK_PLAYER_ABORT_EN
   task automatic test_abort();
      bus.code  = 8'h27;
      bus.start = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         tick();
         if (k == 1) bus.start = 1'b0;
      end
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      total += 3;
      if (bus.btn !== 4'b0000) begin bad++; $display("FAIL abort_btn got=%b want=0000", bus.btn); end
      if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", bus.busy); end
      if (bus.done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", bus.done); end
      for (int k = 0; k < 3; k++) begin
         tick();
         total++;
         if (bus.done !== 1'b0) begin bad++; $display("FAIL abort_quiet k=%0d done=%b want=0", k, bus.done); end
      end
      bus.abort = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.abort = 1'b0;
      bus.start = 1'b0;
      total += 2;
      if (bus.busy !== 1'b1) begin bad++; $display("FAIL abort_start_busy got=%b want=1", bus.busy); end
      if (bus.btn !== 4'b1000) begin bad++; $display("FAIL abort_start_btn got=%b want=1000", bus.btn); end
      for (int k = 0; k < 20; k++) tick();
   endtask
`endif

   initial begin
      rst = 1'b1;
      bus.start   = 1'b0;
      bus.code    = 8'h00;
      bus_f.start = 1'b0;
      bus_f.code  = 8'h00;
`ifdef LOCK_PLAYER_ABORT_EN
      bus.abort   = 1'b0;
      bus_f.abort = 1'b0;
`endif
      test_reset();
      test_default();
      test_repeated();
      test_start_while_busy();
      test_reset_mid();
      test_back_to_back();
      test_fast();
`ifdef LOCK_PLAYER_ABORT_EN
      test_abort();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
